pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the stall, hold and flush controls for the PC, the IF/ID register and the ID/EX register. It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle single/double floating-point operations that must freeze the front of the pipe. It also keeps saturating stall/flush event counters for performance debug.

## Interface
- FP_LAT, 4: stall cycles for a single-precision FP op in EX (≥2)
- DBL_LAT, 8: stall cycles for a double-precision FP op in EX (≥2, ≤15)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs_D, rt_D  in  5  source register fields of the instruction in ID
- uses_rs_D, uses_rt_D  in  1  ID instruction actually reads rs / rt
- float_rs_D, float_rt_D  in  1  that source is read from the FP register file
- dst_X  in  5  destination register of the instruction in EX
- memread_X  in  1  EX instruction is a load
- regwrite_X, regwriteF_X  in  1  EX instruction writes the int / FP register file
- fp_op_X  in  1  EX holds a multi-cycle FP op
- double_X  in  1  that FP op is double precision
- branch_taken_X  in  1  branch/bne/bfpc resolved taken in EX this cycle
- stall_PC, stall_IF_ID  out  1  hold PC / IF/ID contents
- hold_ID_EXE  out  1  hold ID/EX contents (FP freeze)
- flush_IF_ID, flush_ID_EXE  out  1  insert a bubble into that register
- fp_busy  out  1  FSM in FP_WAIT
- stall_cnt, flush_cnt  out  16  saturating event counters

## Operation
- States: RUN, FP_WAIT. A 4-bit down-counter cnt and a 1-bit done_q are also kept.
- Load-use hazard (lu), combinational, evaluated only in RUN:
  - Condition: memread_X and one of the following holds.
  - rs match: uses_rs_D, rs_D==dst_X, and class matches (float_rs_D ? regwriteF_X : regwrite_X && dst_X!=0).
  - rt match: same test using rt.
- RUN, evaluated in priority order:
  1. branch_taken_X: flush_IF_ID=flush_ID_EXE=1, no stall; stay RUN.
  2. fp_op_X && !done_q: stall_PC=stall_IF_ID=hold_ID_EXE=1. Load cnt=(double_X?DBL_LAT:FP_LAT)-2 and go to FP_WAIT.
  3. lu: stall_PC=stall_IF_ID=1, flush_ID_EXE=1 (one bubble); stay RUN.
  4. Otherwise all controls are 0.
- FP_WAIT:
  - stall_PC=stall_IF_ID=hold_ID_EXE=1 and fp_busy=1.
  - branch_taken_X and lu are ignored.
  - If cnt==0: go to RUN and set done_q=1. Otherwise decrement cnt.
- done_q is cleared on every cycle in which it is 1. It blocks re-triggering on the release cycle, when the same FP op is still in EX.
- flush_ID_EXE obliges the ID/EX register to clear every write, memory and branch control (regwrite, regwriteF, memread, memwrite, storeByte, branch, bne, bfpc).
- hold_ID_EXE has priority over flush_ID_EXE at the register. This controller never asserts both.
- stall_cnt increments on every cycle with stall_PC=1. flush_cnt increments on every cycle with flush_IF_ID=1. Both saturate at 16'hFFFF.

## Timing
- Reset values:
  - state=RUN, cnt=0, done_q=0, stall_cnt=flush_cnt=0.
  - All outputs are 0 while in reset, since controls in RUN depend only on inputs, and inputs are gated to 0 during reset.
- Control outputs are combinational from state and inputs, valid in the same cycle. Counters and FSM update on the next edge.
- A load-use hazard costs exactly 1 stall cycle. A taken branch costs 2 flushed slots, IF/ID and ID/EX, in 1 cycle.
- An FP op freezes the pipe for exactly LAT cycles: 1 in RUN plus LAT-1 in FP_WAIT. The op occupies EX for LAT+1 cycles.
- Branch and lu in the same cycle: branch wins, no stall.
- fp_op_X and lu in the same cycle: FP wins, and lu re-evaluates after release.
- Reset asserted mid-FP_WAIT returns immediately to RUN with all controls 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, FP_WAIT}
  - FP_LAT_DEF and DBL_LAT_DEF constants
  - the 16-bit counter width constant
- Sub-module hazard_detect: the combinational load-use comparator, emitting lu.
- The FSM, counters and priority mux live in the top module.

## Test plan
- lw $t0 in EX (dst_X=8, memread_X=1, regwrite_X=1), ID reads rs_D=8 -> stall_PC=stall_IF_ID=flush_ID_EXE=1 for 1 cycle, stall_cnt=1.
- Same as above but dst_X=0 with integer class -> no stall. With float_rs_D=1 and regwriteF_X=1, dst_X=0 -> stall.
- branch_taken_X=1 together with a load-use match -> flush_IF_ID=flush_ID_EXE=1, stall_PC=0, flush_cnt=1.
- fp_op_X=1, double_X=0, FP_LAT=4, held high for 5 cycles -> stall_PC high for exactly 4 cycles, fp_busy high for 3, no re-trigger on cycle 5.
- double_X=1, DBL_LAT=8 -> 8 stall cycles. rst_n pulsed low at stall cycle 3 -> outputs 0 immediately, state RUN, counters 0.
- Force 70000 consecutive stall cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    FP_WAIT = 1'b1
  } state_e;

  localparam int unsigned FP_LAT_DEF  = 4;
  localparam int unsigned DBL_LAT_DEF = 8;
  localparam int unsigned CNT_W       = 16;

  // Saturating increment for the performance event counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
    return (en && (val != {CNT_W{1'b1}})) ? val + 1'b1 : val;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID source that a load in EX is about to write.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       uses_rs_D,
  input  logic       uses_rt_D,
  input  logic       float_rs_D,
  input  logic       float_rt_D,
  input  logic [4:0] dst_X,
  input  logic       memread_X,
  input  logic       regwrite_X,
  input  logic       regwriteF_X,
  output logic       lu
);

  logic int_wr;
  logic rs_class;
  logic rt_class;
  logic rs_hit;
  logic rt_hit;

  // Integer $zero is never a real destination; FP register 0 is.
  assign int_wr   = regwrite_X && (dst_X != 5'd0);
  assign rs_class = float_rs_D ? regwriteF_X : int_wr;
  assign rt_class = float_rt_D ? regwriteF_X : int_wr;

  assign rs_hit = uses_rs_D && (rs_D == dst_X) && rs_class;
  assign rt_hit = uses_rt_D && (rt_D == dst_X) && rt_class;

  assign lu = memread_X && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/hold/flush sequencing for the 5-stage core: load-use, taken branch and multi-cycle FP.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FP_LAT  = FP_LAT_DEF,
  parameter int unsigned DBL_LAT = DBL_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             uses_rs_D,
  input  logic             uses_rt_D,
  input  logic             float_rs_D,
  input  logic             float_rt_D,
  input  logic [4:0]       dst_X,
  input  logic             memread_X,
  input  logic             regwrite_X,
  input  logic             regwriteF_X,
  input  logic             fp_op_X,
  input  logic             double_X,
  input  logic             branch_taken_X,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             hold_ID_EXE,
  output logic             flush_IF_ID,
  output logic             flush_ID_EXE,
  output logic             fp_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One freeze cycle is spent in RUN and the count-down ends at zero.
  localparam logic [3:0] FpLoad  = 4'(FP_LAT - 2);
  localparam logic [3:0] DblLoad = 4'(DBL_LAT - 2);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu;

  hazard_detect u_hazard_detect (
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .uses_rs_D   (uses_rs_D),
    .uses_rt_D   (uses_rt_D),
    .float_rs_D  (float_rs_D),
    .float_rt_D  (float_rt_D),
    .dst_X       (dst_X),
    .memread_X   (memread_X),
    .regwrite_X  (regwrite_X),
    .regwriteF_X (regwriteF_X),
    .lu          (lu)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    hold_ID_EXE  = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EXE = 1'b0;
    fp_busy      = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_taken_X) begin
          flush_IF_ID  = 1'b1;
          flush_ID_EXE = 1'b1;
        end else if (fp_op_X && !done_q) begin
          stall_PC    = 1'b1;
          stall_IF_ID = 1'b1;
          hold_ID_EXE = 1'b1;
          cnt_d       = double_X ? DblLoad : FpLoad;
          state_d     = FP_WAIT;
        end else if (lu) begin
          stall_PC     = 1'b1;
          stall_IF_ID  = 1'b1;
          flush_ID_EXE = 1'b1;
        end
      end

      FP_WAIT: begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        hold_ID_EXE = 1'b1;
        fp_busy     = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
          // Suppresses re-trigger while the finished op still sits in EX.
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      stall_cnt_q <= sat_inc(stall_cnt_q, stall_PC);
      flush_cnt_q <= sat_inc(flush_cnt_q, flush_IF_ID);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_D, rt_D, dst_X;
  logic        uses_rs_D, uses_rt_D, float_rs_D, float_rt_D;
  logic        memread_X, regwrite_X, regwriteF_X;
  logic        fp_op_X, double_X, branch_taken_X;
  logic        stall_PC, stall_IF_ID, hold_ID_EXE, flush_IF_ID, flush_ID_EXE, fp_busy;
  logic [15:0] stall_cnt, flush_cnt;

  int total;
  int bad;

  pipe_hazard_ctrl #(
    .FP_LAT  (4),
    .DBL_LAT (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_D           (rs_D),
    .rt_D           (rt_D),
    .uses_rs_D      (uses_rs_D),
    .uses_rt_D      (uses_rt_D),
    .float_rs_D     (float_rs_D),
    .float_rt_D     (float_rt_D),
    .dst_X          (dst_X),
    .memread_X      (memread_X),
    .regwrite_X     (regwrite_X),
    .regwriteF_X    (regwriteF_X),
    .fp_op_X        (fp_op_X),
    .double_X       (double_X),
    .branch_taken_X (branch_taken_X),
    .stall_PC       (stall_PC),
    .stall_IF_ID    (stall_IF_ID),
    .hold_ID_EXE    (hold_ID_EXE),
    .flush_IF_ID    (flush_IF_ID),
    .flush_ID_EXE   (flush_ID_EXE),
    .fp_busy        (fp_busy),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_D = 5'd0; rt_D = 5'd0; dst_X = 5'd0;
    uses_rs_D = 1'b0; uses_rt_D = 1'b0; float_rs_D = 1'b0; float_rt_D = 1'b0;
    memread_X = 1'b0; regwrite_X = 1'b0; regwriteF_X = 1'b0;
    fp_op_X = 1'b0; double_X = 1'b0; branch_taken_X = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs the six control outputs {stall_PC,stall_IF_ID,hold,flush_IF_ID,flush_ID_EXE,fp_busy}.
  function automatic logic [31:0] ctl();
    return {26'd0, stall_PC, stall_IF_ID, hold_ID_EXE, flush_IF_ID, flush_ID_EXE, fp_busy};
  endfunction

  task automatic load_use_rs(input logic [4:0] reg_no);
    clear_inputs();
    memread_X = 1'b1; regwrite_X = 1'b1; dst_X = reg_no;
    uses_rs_D = 1'b1; rs_D = reg_no;
  endtask

  initial begin
    int n_stall, n_busy, n_fid, n_hold;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", ctl(), 32'h0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Integer load-use on rs: one stall cycle with a bubble into ID/EX
    load_use_rs(5'd8);
    @(negedge clk);
    check("lu_rs_ctl", ctl(), 32'b110010);
    tick();
    clear_inputs();
    #1;
    check("lu_rs_cnt", 32'(stall_cnt), 32'd1);
    check("lu_rs_release", ctl(), 32'h0);

    // Integer $zero destination never hazards
    load_use_rs(5'd0);
    #1;
    check("lu_zero_int", ctl(), 32'h0);

    // FP register 0 does hazard
    regwrite_X = 1'b0; regwriteF_X = 1'b1; float_rs_D = 1'b1;
    #1;
    check("lu_zero_fp", ctl(), 32'b110010);
    tick();

    // rt match only
    clear_inputs();
    memread_X = 1'b1; regwrite_X = 1'b1; dst_X = 5'd5; uses_rt_D = 1'b1; rt_D = 5'd5;
    rs_D = 5'd5;
    #1;
    check("lu_rt", ctl(), 32'b110010);
    tick();
    check("lu_rt_cnt", 32'(stall_cnt), 32'd3);

    // Not read, not a load, or wrong register class: no hazard
    uses_rt_D = 1'b0;
    #1;
    check("lu_unused", ctl(), 32'h0);
    load_use_rs(5'd8);
    memread_X = 1'b0;
    #1;
    check("lu_no_load", ctl(), 32'h0);
    load_use_rs(5'd8);
    float_rs_D = 1'b1;
    #1;
    check("lu_class_mismatch", ctl(), 32'h0);

    // Taken branch beats load-use
    load_use_rs(5'd8);
    branch_taken_X = 1'b1;
    #1;
    check("branch_lu_ctl", ctl(), 32'b000110);
    tick();
    clear_inputs();
    #1;
    check("branch_flush_cnt", 32'(flush_cnt), 32'd1);
    check("branch_stall_cnt", 32'(stall_cnt), 32'd3);

    // Single FP op held 5 cycles alongside a load-use: 4 frozen, 3 busy, lu on the 5th
    load_use_rs(5'd9);
    fp_op_X = 1'b1;
    n_stall = 0; n_busy = 0; n_fid = 0; n_hold = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_stall += int'(stall_PC);
      n_busy  += int'(fp_busy);
      n_fid   += int'(flush_ID_EXE);
      n_hold  += int'(hold_ID_EXE);
      tick();
    end
    check("sp_stall_cycles", 32'(n_stall), 32'd4);
    check("sp_hold_cycles", 32'(n_hold), 32'd4);
    check("sp_busy_cycles", 32'(n_busy), 32'd3);
    check("sp_no_flush", 32'(n_fid), 32'd0);
    @(negedge clk);
    check("sp_release_lu", ctl(), 32'b110010);
    tick();
    clear_inputs();
    #1;
    check("sp_stall_cnt", 32'(stall_cnt), 32'd8);
    check("sp_idle", ctl(), 32'h0);

    // Double FP op held 9 cycles: 8 frozen, 7 busy, no re-trigger on the 9th
    fp_op_X = 1'b1; double_X = 1'b1;
    n_stall = 0; n_busy = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_stall += int'(stall_PC);
      n_busy  += int'(fp_busy);
      tick();
    end
    check("dp_stall_cycles", 32'(n_stall), 32'd8);
    check("dp_busy_cycles", 32'(n_busy), 32'd7);
    clear_inputs();
    #1;
    check("dp_stall_cnt", 32'(stall_cnt), 32'd16);

    // Reset in the third stall cycle of a double op
    fp_op_X = 1'b1; double_X = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("dp_rst_pre", ctl(), 32'b111001);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("dp_rst_ctl", ctl(), 32'h0);
    check("dp_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("dp_rst_flush_cnt", 32'(flush_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("dp_rst_run", ctl(), 32'h0);
    fp_op_X = 1'b1;
    #1;
    check("dp_rst_fresh_fp", ctl(), 32'b111000);
    tick();
    clear_inputs();
    repeat (8) tick();
    check("dp_rst_back_idle", ctl(), 32'h0);

    // Long continuous load-use saturates the stall counter
    load_use_rs(5'd12);
    repeat (70000) @(posedge clk);
    #1;
    check("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_still_stalling", 32'(stall_PC), 32'd1);
    tick();
    check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
